// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter and sequencer for the single-port byte-lane data memory.
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise D always beats F.
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_f_valid,
  input  logic [31:0] i_f_addr,
  output logic        o_f_ready,
  output logic        o_f_rvalid,
  output logic [31:0] o_f_rdata,
  input  logic        i_d_valid,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [1:0]  i_d_wr_mask,
  input  logic [2:0]  i_d_rd_mask,
  output logic        o_d_ready,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [1:0]  o_d_err,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_misaligned,
  input  logic        i_mem_err_invalid_rd,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] WR_N  = 2'd0;
  localparam logic [2:0] RD_W  = 3'd0;
  localparam logic [2:0] RD_XX = 3'd5;

  state_t state, next_state;
  logic   owner_d;
  logic   can_accept;
  logic   grant_d;
  logic   accept;
  logic   d_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // Remembers the most recent grant so a tie goes to the other port next time.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      last_d <= 1'b0;
    else if (accept)
      last_d <= grant_d;
  end

  assign d_wins_tie = !last_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  assign can_accept = i_reset && (state == IDLE || state == RESP);
  assign grant_d    = i_d_valid && (!i_f_valid || d_wins_tie);
  assign accept     = can_accept && (i_f_valid || i_d_valid);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? ACCESS : IDLE;
      ACCESS:  next_state = RESP;
      RESP:    next_state = accept ? ACCESS : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_f_ready  = can_accept && i_f_valid && !grant_d;
    o_d_ready  = can_accept && grant_d;
    o_f_rvalid = (state == RESP) && !owner_d;
    o_d_rvalid = (state == RESP) && owner_d;
    o_busy     = (state != IDLE);
    o_d_err    = o_d_rvalid ? {i_mem_err_misaligned, i_mem_err_invalid_rd} : 2'b00;
  end

  assign o_f_rdata = i_mem_rd_data;
  assign o_d_rdata = i_mem_rd_data;

  // Masks fall back to no-op after ACCESS so the memory never repeats a command.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      owner_d       <= 1'b0;
      o_mem_address <= 32'h0;
      o_mem_wr_data <= 32'h0;
      o_mem_wr_mask <= WR_N;
      o_mem_rd_mask <= RD_XX;
    end else if (accept) begin
      owner_d <= grant_d;
      if (grant_d) begin
        o_mem_address <= i_d_addr;
        o_mem_wr_data <= i_d_wdata;
        o_mem_wr_mask <= i_d_wr_mask;
        o_mem_rd_mask <= i_d_rd_mask;
      end else begin
        o_mem_address <= i_f_addr;
        o_mem_wr_data <= 32'h0;
        o_mem_wr_mask <= WR_N;
        o_mem_rd_mask <= RD_W;
      end
    end else if (state == ACCESS) begin
      o_mem_wr_mask <= WR_N;
      o_mem_rd_mask <= RD_XX;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte-lane memory model; honours ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_f_valid;
  logic [31:0] i_f_addr;
  logic        o_f_ready, o_f_rvalid;
  logic [31:0] o_f_rdata;
  logic        i_d_valid;
  logic [31:0] i_d_addr, i_d_wdata;
  logic [1:0]  i_d_wr_mask;
  logic [2:0]  i_d_rd_mask;
  logic        o_d_ready, o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic [1:0]  o_d_err;
  logic [31:0] o_mem_address, o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_err_misaligned, i_mem_err_invalid_rd;
  logic        o_busy;

  mem_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_f_valid(i_f_valid), .i_f_addr(i_f_addr), .o_f_ready(o_f_ready),
    .o_f_rvalid(o_f_rvalid), .o_f_rdata(o_f_rdata),
    .i_d_valid(i_d_valid), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_wr_mask(i_d_wr_mask), .i_d_rd_mask(i_d_rd_mask), .o_d_ready(o_d_ready),
    .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data), .i_mem_err_misaligned(i_mem_err_misaligned),
    .i_mem_err_invalid_rd(i_mem_err_invalid_rd), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rd_extract(logic [31:0] w, logic [1:0] a, logic [2:0] rd);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[{a, 3'b000} +: 8];
    case (rd)
      3'd0:    return w;
      3'd1:    return {16'h0, h};
      3'd2:    return {24'h0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {{24{b[7]}}, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_misaligned(logic [1:0] a, logic [1:0] wr);
    return (wr == 2'd2 && a[0]) || (wr == 2'd3 && a != 2'd0);
  endfunction

  function automatic logic [31:0] wr_apply(logic [31:0] w, logic [1:0] a, logic [1:0] wr, logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (wr)
      2'd1: r[{a, 3'b000} +: 8] = d[7:0];
      2'd2: r[{a[1], 4'b0000} +: 16] = d[15:0];
      2'd3: r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  // Memory model: reads registered, read returns pre-write contents, misaligned writes are dropped.
  logic [31:0] mem [0:63];
  bit          preloaded = 1'b0;
  always @(posedge i_clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 2) ? 32'h1234_5678 : 32'h0;
      preloaded            <= 1'b1;
      i_mem_rd_data        <= 32'h0;
      i_mem_err_misaligned <= 1'b0;
      i_mem_err_invalid_rd <= 1'b0;
    end else begin
      i_mem_rd_data        <= rd_extract(mem[o_mem_address[7:2]], o_mem_address[1:0], o_mem_rd_mask);
      i_mem_err_invalid_rd <= (o_mem_rd_mask > 3'd5);
      i_mem_err_misaligned <= is_misaligned(o_mem_address[1:0], o_mem_wr_mask);
      if (!is_misaligned(o_mem_address[1:0], o_mem_wr_mask) && o_mem_wr_mask != 2'd0)
        mem[o_mem_address[7:2]] <= wr_apply(mem[o_mem_address[7:2]], o_mem_address[1:0],
                                            o_mem_wr_mask, o_mem_wr_data);
    end
  end

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic [1:0]  err;
    bit          chk_data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:63];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          f_acc = 0, d_acc = 0, f_rsp = 0, d_rsp = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Observe one cycle at the falling edge: record accepts, score responses.
  task automatic sample_cycle();
    exp_t e;
    logic [5:0] idx;
    @(negedge i_clk);
    if (!i_reset) begin
      sb.delete();
    end else begin
      if (i_f_valid && o_f_ready) begin
        e.is_d = 1'b0; e.data = ref_mem[i_f_addr[7:2]]; e.err = 2'b00; e.chk_data = 1'b1;
        sb.push_back(e);
        f_acc++;
      end
      if (i_d_valid && o_d_ready) begin
        idx        = i_d_addr[7:2];
        e.is_d     = 1'b1;
        e.data     = rd_extract(ref_mem[idx], i_d_addr[1:0], i_d_rd_mask);
        e.chk_data = (i_d_rd_mask <= 3'd4);
        e.err      = {is_misaligned(i_d_addr[1:0], i_d_wr_mask), i_d_rd_mask > 3'd5};
        if (!e.err[1] && i_d_wr_mask != 2'd0)
          ref_mem[idx] = wr_apply(ref_mem[idx], i_d_addr[1:0], i_d_wr_mask, i_d_wdata);
        sb.push_back(e);
        d_acc++;
      end
      if (o_f_rvalid || o_d_rvalid) begin
        checkOutput("dual_rvalid", {31'h0, o_f_rvalid && o_d_rvalid}, 32'h0);
        if (sb.size() == 0) begin
          checkOutput("spurious_rvalid", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_port", {31'h0, o_d_rvalid}, {31'h0, e.is_d});
          if (o_d_rvalid) begin
            d_rsp++;
            if (e.chk_data) checkOutput("d_rdata", o_d_rdata, e.data);
            checkOutput("d_err", {30'h0, o_d_err}, {30'h0, e.err});
          end else begin
            f_rsp++;
            checkOutput("f_rdata", o_f_rdata, e.data);
          end
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] wr, input logic [2:0] rd);
    bit done;
    done = 1'b0;
    if (is_d) begin
      i_d_valid = 1'b1; i_d_addr = addr; i_d_wdata = wdata; i_d_wr_mask = wr; i_d_rd_mask = rd;
    end else begin
      i_f_valid = 1'b1; i_f_addr = addr;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      sample_cycle();
      done = is_d ? o_d_ready : o_f_ready;
      advance();
    end
    if (!done) checkOutput("accept_timeout", 32'h0, 32'h1);
    i_d_valid = 1'b0;
    i_f_valid = 1'b0;
    i_d_addr  = $urandom;
    i_d_wdata = $urandom;
    i_f_addr  = $urandom;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample_cycle();
      done = (sb.size() == 0) && !o_busy;
      advance();
    end
    checkOutput("drain", sb.size(), 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_addr"}, o_mem_address, 32'h0);
    checkOutput({tag, "_wdata"}, o_mem_wr_data, 32'h0);
    checkOutput({tag, "_wrmask"}, {30'h0, o_mem_wr_mask}, 32'h0);
    checkOutput({tag, "_rdmask"}, {29'h0, o_mem_rd_mask}, 32'h5);
    checkOutput({tag, "_rvalids"}, {30'h0, o_f_rvalid, o_d_rvalid}, 32'h0);
    checkOutput({tag, "_readies"}, {30'h0, o_f_ready, o_d_ready}, 32'h0);
    checkOutput({tag, "_derr"}, {30'h0, o_d_err}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    int f0, d0, fr0, dr0;
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 2) ? 32'h1234_5678 : 32'h0;
    i_reset = 1'b0;
    i_f_valid = 1'b1; i_f_addr = 32'h8;
    i_d_valid = 1'b1; i_d_addr = 32'h0; i_d_wdata = 32'h0; i_d_wr_mask = 2'd0; i_d_rd_mask = 3'd0;
    sample_cycle();
    check_reset_values("reset");
    advance();
    advance();
    i_f_valid = 1'b0; i_d_valid = 1'b0;
    i_reset = 1'b1;
    advance();

    // Single fetch, checked cycle by cycle.
    i_f_valid = 1'b1; i_f_addr = 32'h8;
    sample_cycle();
    checkOutput("fetch_ready_c0", {31'h0, o_f_ready}, 32'h1);
    advance();
    i_f_valid = 1'b0;
    sample_cycle();
    checkOutput("fetch_rdmask_c1", {29'h0, o_mem_rd_mask}, 32'h0);
    checkOutput("fetch_addr_c1", o_mem_address, 32'h8);
    checkOutput("fetch_ready_c1", {31'h0, o_f_ready}, 32'h0);
    advance();
    fr0 = f_rsp;
    sample_cycle();
    checkOutput("fetch_rvalid_c2", {31'h0, o_f_rvalid}, 32'h1);
    checkOutput("fetch_rsp_seen", f_rsp - fr0, 32'h1);
    advance();
    sample_cycle();
    checkOutput("fetch_idle_c3", {30'h0, o_busy, o_f_rvalid}, 32'h0);
    checkOutput("fetch_masks_c3", {27'h0, o_mem_wr_mask, o_mem_rd_mask}, 32'h5);
    advance();

    // Store word, then sign-extended byte load of the top byte.
    dr0 = d_rsp;
    applyStimulus(1'b1, 32'h10, 32'hAABB_CCDD, 2'd3, 3'd5);
    wait_idle();
    applyStimulus(1'b1, 32'h13, 32'h0, 2'd0, 3'd4);
    wait_idle();
    checkOutput("store_load_rsps", d_rsp - dr0, 32'h2);

    // Both ports requesting continuously.
    f0 = f_acc; d0 = d_acc; fr0 = f_rsp; dr0 = d_rsp;
    i_f_valid = 1'b1; i_f_addr = 32'h8;
    i_d_valid = 1'b1; i_d_addr = 32'h10; i_d_wdata = 32'h0; i_d_wr_mask = 2'd0; i_d_rd_mask = 3'd0;
    for (int i = 0; i < 12; i++) begin
      sample_cycle();
      advance();
    end
    i_f_valid = 1'b0; i_d_valid = 1'b0;
    wait_idle();
    checkOutput("contend_total_rsps", (f_rsp - fr0) + (d_rsp - dr0), 32'd6);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("contend_f_grants", f_acc - f0, 32'd3);
    checkOutput("contend_d_grants", d_acc - d0, 32'd3);
`else
    checkOutput("contend_f_grants", f_acc - f0, 32'd0);
    checkOutput("contend_d_grants", d_acc - d0, 32'd6);
    checkOutput("contend_f_rsps", f_rsp - fr0, 32'd0);
`endif

    // Error flags: misaligned halfword store, invalid read mask.
    applyStimulus(1'b1, 32'h21, 32'h0000_BEEF, 2'd2, 3'd5);
    wait_idle();
    applyStimulus(1'b1, 32'h20, 32'h0, 2'd0, 3'd6);
    wait_idle();
    applyStimulus(1'b1, 32'h22, 32'h0000_BEEF, 2'd2, 3'd0);
    wait_idle();
    applyStimulus(1'b1, 32'h20, 32'h0, 2'd0, 3'd0);
    wait_idle();

    // Reset pulled low in the ACCESS cycle of a load.
    applyStimulus(1'b1, 32'h10, 32'h0, 2'd0, 3'd0);
    i_reset = 1'b0;
    sample_cycle();
    check_reset_values("midreset");
    advance();
    sample_cycle();
    checkOutput("midreset_no_rvalid", {30'h0, o_f_rvalid, o_d_rvalid}, 32'h0);
    advance();
    i_reset = 1'b1;
    dr0 = d_rsp; fr0 = f_rsp;
    for (int i = 0; i < 4; i++) begin
      sample_cycle();
      advance();
    end
    checkOutput("postreset_no_rsp", (d_rsp - dr0) + (f_rsp - fr0), 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, 2'd0, 3'd0);
    wait_idle();
    checkOutput("postreset_fetch", f_rsp - fr0, 32'h1);

    // Random mix of fetches and loads/stores.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1)
        applyStimulus(1'b1, {24'h0, 8'($urandom_range(0, 255))}, $urandom,
                      2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)));
      else
        applyStimulus(1'b0, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, 32'h0, 2'd0, 3'd0);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
